// File: rtl/hex_display_scan_if.sv
// hex_display_scan_if -- display-driver bus between the datapath and the scanner.
//   master (datapath side): drives load/value/dp_mask/blank_en[/blink_mask],
//                           observes seg_out/digit_en
//   slave  (scanner side) : the reverse
// Optional macro HEX_BLINK_EN adds blink_mask.
interface hex_display_scan_if #(parameter int DIGITS = 4);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_mask;
  logic                  blank_en;
`ifdef HEX_BLINK_EN
  logic [DIGITS-1:0]     blink_mask;
`endif
  logic [7:0]            seg_out;
  logic [DIGITS-1:0]     digit_en;

`ifdef HEX_BLINK_EN
  modport master (output load, value, dp_mask, blank_en, blink_mask,
                  input  seg_out, digit_en);
  modport slave  (input  load, value, dp_mask, blank_en, blink_mask,
                  output seg_out, digit_en);
`else
  modport master (output load, value, dp_mask, blank_en,
                  input  seg_out, digit_en);
  modport slave  (input  load, value, dp_mask, blank_en,
                  output seg_out, digit_en);
`endif
endinterface

// File: rtl/hex_display_scan.sv
// hex_display_scan -- time-multiplexed driver for DIGITS common-anode
// 7-segment hex digits.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.load/value/dp_mask : captured into shadow registers on load
//   bus.blank_en           : live leading-zero blanking enable
//   bus.seg_out            : active-low segments {dp,g..a}
//   bus.digit_en           : active-low anodes, at most one low
// Each digit slot lasts REFRESH_DIV cycles: REFRESH_DIV-1 SHOW cycles then
// one dark GAP cycle so the previous digit's pattern never ghosts onto the
// next anode. Outputs are registered from the current counters/shadow.
// Optional macro HEX_BLINK_EN adds bus.blink_mask and parameter BLINK_SCANS.
module hex_display_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
`ifdef HEX_BLINK_EN
  , parameter int BLINK_SCANS = 64
`endif
) (
  input logic clk,
  input logic rst_n,
  hex_display_scan_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  logic [4*DIGITS-1:0] sh_val;
  logic [DIGITS-1:0]   sh_dp;
  logic [CW-1:0]       div_cnt;
  logic [IW-1:0]       idx;

  logic                wrap, last_dig;
  logic [DIGITS-1:0]   zero_above;   // nibbles i..DIGITS-1 all zero
  logic [3:0]          nib;
  logic [6:0]          code;
  logic [7:0]          nxt_seg;
  logic [DIGITS-1:0]   nxt_en;

  assign wrap     = (div_cnt == CW'(REFRESH_DIV - 1));
  assign last_dig = (idx == IW'(DIGITS - 1));
  assign nib      = sh_val[{idx, 2'b00} +: 4];

`ifdef HEX_BLINK_EN
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  logic [BW-1:0] rnd_cnt;
  logic          blink_phase;
`endif

  always_comb begin
    zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i == DIGITS - 1) zero_above[i] = (sh_val[4*i +: 4] == 4'h0);
      else                 zero_above[i] = zero_above[i+1] & (sh_val[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    case (nib)
      4'h0: code = 7'h40;  4'h1: code = 7'h79;
      4'h2: code = 7'h24;  4'h3: code = 7'h30;
      4'h4: code = 7'h19;  4'h5: code = 7'h12;
      4'h6: code = 7'h02;  4'h7: code = 7'h78;
      4'h8: code = 7'h00;  4'h9: code = 7'h18;
      4'hA: code = 7'h08;  4'hB: code = 7'h03;
      4'hC: code = 7'h46;  4'hD: code = 7'h21;
      4'hE: code = 7'h06;  default: code = 7'h0E;
    endcase
  end

  always_comb begin
    nxt_seg = 8'hFF;
    nxt_en  = '1;
    if (!wrap) begin
      nxt_en  = ~(DIGITS'(1) << idx);
      // digit 0 is never blanked so an all-zero value still reads "0"
      nxt_seg = {~sh_dp[idx],
                 (bus.blank_en && idx != '0 && zero_above[idx]) ? 7'h7F : code};
`ifdef HEX_BLINK_EN
      if (blink_phase && bus.blink_mask[idx]) nxt_seg = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_val       <= '0;
      sh_dp        <= '0;
      div_cnt      <= '0;
      idx          <= '0;
      bus.seg_out  <= 8'hFF;
      bus.digit_en <= '1;
    end else begin
      if (bus.load) begin
        sh_val <= bus.value;
        sh_dp  <= bus.dp_mask;
      end
      div_cnt      <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) idx <= last_dig ? '0 : idx + 1'b1;
      bus.seg_out  <= nxt_seg;
      bus.digit_en <= nxt_en;
    end
  end

`ifdef HEX_BLINK_EN
  // one round = full pass over all digits; phase flips every BLINK_SCANS rounds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rnd_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (wrap && last_dig) begin
      if (rnd_cnt == BW'(BLINK_SCANS - 1)) begin
        rnd_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        rnd_cnt <= rnd_cnt + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_hex_display_scan.sv
module tb_hex_display_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nassert = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  hex_display_scan_if #(.DIGITS(4)) bus ();

`ifdef HEX_BLINK_EN
  hex_display_scan #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_SCANS(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`else
  hex_display_scan #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // advance one edge, then compare the registered outputs
  task automatic chk(input string tag, input logic [3:0] en, input logic [7:0] seg);
    @(posedge clk); #1;
    nassert++;
    assert ({bus.digit_en, bus.seg_out} === {en, seg})
      else begin
        nfail++;
        $error("FAIL %s: got en=%b seg=%h, expected en=%b seg=%h",
               tag, bus.digit_en, bus.seg_out, en, seg);
      end
  endtask

  // one full slot: 3 SHOW cycles then the dark GAP
  task automatic slot(input string tag, input logic [3:0] en, input logic [7:0] seg);
    for (int i = 0; i < 3; i++) chk(tag, en, seg);
    chk({tag, "_gap"}, 4'b1111, 8'hFF);
  endtask

  task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] dp,
                       input logic be);
    bus.load = ld; bus.value = v; bus.dp_mask = dp; bus.blank_en = be;
  endtask

  initial begin
`ifdef HEX_BLINK_EN
    bus.blink_mask = 4'b0000;
`endif
    // reset held 3 cycles; a load during reset must be ignored
    drive(1'b1, 16'h1A3F, 4'b0000, 1'b0);
    rst_n = 1'b0;
    chk("rst0", 4'b1111, 8'hFF);
    chk("rst1", 4'b1111, 8'hFF);
    chk("rst2", 4'b1111, 8'hFF);
    rst_n = 1'b1;
    drive(1'b0, 16'h1A3F, 4'b0000, 1'b0);
    chk("first_show", 4'b1110, 8'hC0);

    // scan order
    drive(1'b1, 16'h1A3F, 4'b0000, 1'b0);
    chk("load_edge", 4'b1110, 8'hC0);
    bus.load = 1'b0;
    chk("d0_new", 4'b1110, 8'h8E);
    chk("d0_gap", 4'b1111, 8'hFF);
    slot("scan_d1", 4'b1101, 8'hB0);
    slot("scan_d2", 4'b1011, 8'h88);
    slot("scan_d3", 4'b0111, 8'hF9);
    slot("scan_d0", 4'b1110, 8'h8E);

    // leading-zero blanking, load lands at start of digit-1 slot
    drive(1'b1, 16'h0007, 4'b0100, 1'b1);
    chk("blk_old", 4'b1101, 8'hB0);
    bus.load = 1'b0;
    chk("blk_d1a", 4'b1101, 8'hFF);
    chk("blk_d1b", 4'b1101, 8'hFF);
    chk("blk_d1g", 4'b1111, 8'hFF);
    slot("blk_d2", 4'b1011, 8'h7F);
    slot("blk_d3", 4'b0111, 8'hFF);
    slot("blk_d0", 4'b1110, 8'hF8);

    // all-zero value: only digit 0 lit
    drive(1'b1, 16'h0000, 4'b0000, 1'b1);
    chk("z_d1a", 4'b1101, 8'hFF);
    bus.load = 1'b0;
    chk("z_d1b", 4'b1101, 8'hFF);
    chk("z_d1c", 4'b1101, 8'hFF);
    chk("z_d1g", 4'b1111, 8'hFF);
    slot("z_d2", 4'b1011, 8'hFF);
    slot("z_d3", 4'b0111, 8'hFF);
    slot("z_d0", 4'b1110, 8'hC0);

    // load mid-slot: digit 2 switches 3 -> 5 with no gap inserted
    drive(1'b1, 16'h0300, 4'b0000, 1'b0);
    chk("m_d1a", 4'b1101, 8'hC0);
    bus.load = 1'b0;
    chk("m_d1b", 4'b1101, 8'hC0);
    chk("m_d1c", 4'b1101, 8'hC0);
    chk("m_d1g", 4'b1111, 8'hFF);
    chk("m_d2_3", 4'b1011, 8'hB0);
    drive(1'b1, 16'h0500, 4'b0000, 1'b0);
    chk("m_d2_3b", 4'b1011, 8'hB0);
    bus.load = 1'b0;
    chk("m_d2_5", 4'b1011, 8'h92);
    chk("m_d2_gap", 4'b1111, 8'hFF);
    chk("m_d3", 4'b0111, 8'hC0);

    // reset mid-scan during digit 3 SHOW
    rst_n = 1'b0;
    chk("mid_rst", 4'b1111, 8'hFF);
    rst_n = 1'b1;
    slot("post_rst_d0", 4'b1110, 8'hC0);
    slot("post_rst_d1", 4'b1101, 8'hC0);
    slot("post_rst_d2", 4'b1011, 8'hC0);

`ifdef HEX_BLINK_EN
    rst_n = 1'b0;
    chk("b_rst", 4'b1111, 8'hFF);
    rst_n = 1'b1;
    bus.blink_mask = 4'b0001;
    drive(1'b1, 16'h1234, 4'b0000, 1'b0);
    chk("b_first", 4'b1110, 8'hC0);
    bus.load = 1'b0;
    chk("b_r0_d0a", 4'b1110, 8'h99);
    chk("b_r0_d0b", 4'b1110, 8'h99);
    chk("b_r0_gap", 4'b1111, 8'hFF);
    slot("b_r0_d1", 4'b1101, 8'hB0);
    slot("b_r0_d2", 4'b1011, 8'hA4);
    slot("b_r0_d3", 4'b0111, 8'hF9);
    for (int r = 1; r < 6; r++) begin
      // rounds 0,1 lit; 2,3 blinked; 4,5 lit
      slot("b_d0", 4'b1110, (r == 2 || r == 3) ? 8'hFF : 8'h99);
      slot("b_d1", 4'b1101, 8'hB0);
      slot("b_d2", 4'b1011, 8'hA4);
      slot("b_d3", 4'b0111, 8'hF9);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Parametrised, time-multiplexed driver for DIGITS common-anode 7-segment hex digits, replacing one decoder per digit.
- Latches a packed hex value, scans digits round-robin with a dead-time gap between digits, and provides optional leading-zero blanking and per-digit decimal points.
- Sits between datapath result registers (e.g. S-DES key/plaintext/ciphertext) and board display pins.

Parameters:
- DIGITS, 4, number of digits (1..8); value width 4*DIGITS
- REFRESH_DIV, 50000, clock cycles per digit slot (min 2), including 1 gap cycle

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load  in  1  capture value/dp_mask into shadow registers this edge
- value  in  4*DIGITS  packed nibbles; digit i = value[4i+3:4i], digit 0 rightmost
- dp_mask  in  DIGITS  1 = light decimal point of digit i
- blank_en  in  1  1 = leading-zero blanking on
- seg_out  out  8  active-low segments; bit7 = dp, bits6:0 = g..a
- digit_en  out  DIGITS  active-low anode enables, at most one low

Behaviour:
- Reset (clk edge with rst_n=0): shadow value=0, shadow dp=0, div_cnt=0, idx=0, seg_out=8'hFF, digit_en=all ones. Reset mid-scan aborts immediately, with no partial slot.
- Counters: div_cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, idx = (idx==DIGITS-1) ? 0 : idx+1.
- Slot phases:
  - div_cnt 0..REFRESH_DIV-2 is SHOW.
  - div_cnt==REFRESH_DIV-1 is GAP: digit_en all ones, seg_out 8'hFF (anti-ghosting).
- Outputs are registered. The values in cycle t+1 are computed from idx, div_cnt and the shadow registers at the end of cycle t. Net latency of 1 clock.
- SHOW output: digit_en = ~(1<<idx). seg_out[6:0] comes from the nibble code table below. seg_out[7] = ~dp_shadow[idx].
- Code table (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=98, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Load: the shadow registers update on the edge where load=1, and the next registered output uses the new shadow. load during reset is ignored. load held high recaptures every cycle.
- Leading-zero blanking: digit i (i>=1) is blank when blank_en=1 and nibbles i..DIGITS-1 are all 0.
  - Blank digit: seg_out[6:0]=7'h7F, anode still enabled, dp still honoured.
  - Digit 0 is never blanked, so value 0 shows "0".
- blank_en is sampled live each cycle and is not shadowed.
- Simultaneous load and slot wrap: the new idx displays the new shadow value.
- DIGITS=1: idx stays 0 and the GAP still occurs once per slot.

Optional Feature:
- Macro HEX_BLINK_EN. When defined, the block adds:
  - parameter BLINK_SCANS (default 64): full scan rounds per half blink period
  - input blink_mask[DIGITS-1:0]
  - internal scan-round counter and blink_phase flop, both reset to 0
- blink_phase toggles on the slot wrap where idx goes DIGITS-1 -> 0 and the round counter hits BLINK_SCANS-1; the counter then restarts at 0.
- While blink_phase=1, SHOW for a digit with blink_mask[idx]=1 outputs seg_out=8'hFF (dp also off). The anode is still enabled.
- Without the macro: the port, parameter and counters are absent, and the display is never blinked.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> seg_out=8'hFF and digit_en=4'b1111 from the first edge; release -> first SHOW output is digit 0 one cycle later.
- Scan order, DIGITS=4, REFRESH_DIV=4: load value=16'h1A3F, dp_mask=0, blank_en=0 -> repeating 3 SHOW cycles per slot with (digit_en, seg_out) = (1110, 8E), (1101, B0), (1011, 88), (0111, F9), each slot followed by 1 cycle of (1111, FF).
- Blanking: value=16'h0007, blank_en=1, dp_mask=4'b0100 -> digit0 F8; digit1 FF; digit2 7F; digit3 FF. Value=16'h0000 -> digit0 C0, others FF.
- Load mid-slot: with digit 2 showing 3 (B0), pulse load with value=16'h0500 -> the next cycle digit 2 shows 92 with no gap inserted; scan timing is unchanged.
- Reset mid-scan: assert rst_n=0 during idx=3 SHOW -> next cycle FF/1111; after release, the scan restarts at digit 0 and the shadow value reads 0 (digit0 C0).
- HEX_BLINK_EN, BLINK_SCANS=2, blink_mask=4'b0001, value=16'h1234 -> digit 0 shows 99 for 2 rounds and FF for 2 rounds, alternating; digits 1-3 are never blanked.
